// File: rtl/wordsync_pkg.sv
// Shared types and helpers for the word-synchronizer arbiter family.
package wordsync_pkg;

   // Arbiter sequencing: idle, waiting for srdy to fall, waiting for srdy
   // to rise again, and a sticky fault after a hung handshake.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LO = 2'd1,
      WAIT_HI = 2'd2,
      FAULT   = 2'd3
   } state_t;

   // Watchdog counter width; limits the usable timeout to 1..1023 cycles.
   localparam int WDOG_W = 10;

   // Ceiling log2, used for requester-ID widths at elaboration time.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wordsync_arbiter_if.sv
// Requester and synchronizer-side signals of the word-sync arbiter.
// master: the arbiter itself. slave: the surrounding producers/synchronizer.
interface wordsync_arbiter_if
   import wordsync_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 32,
   parameter int IDW    = clog2(NREQ)
) ();

   // Requester side.
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        gnt;

   // Synchronizer source port.
   logic [IDW+DWIDTH-1:0]  sync_din;
   logic                   sync_din_en;
   logic                   sync_srdy;

   // Status and fault control.
   logic                   busy;
   logic [IDW-1:0]         cur_id;
   logic                   timeout_err;
   logic                   clr_err;

   modport master (
      input  req,
      input  req_data,
      input  sync_srdy,
      input  clr_err,
      output gnt,
      output sync_din,
      output sync_din_en,
      output busy,
      output cur_id,
      output timeout_err
   );

   modport slave (
      output req,
      output req_data,
      output sync_srdy,
      output clr_err,
      input  gnt,
      input  sync_din,
      input  sync_din_en,
      input  busy,
      input  cur_id,
      input  timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// searching upward from rr_ptr+1 and wrapping modulo NREQ, so the last
// winner has the lowest priority. Works for any NREQ, power of two or not.
module rr_pick
   import wordsync_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            valid,
   output logic [IDW-1:0]  winner
);

   int             idx;
   logic [IDW-1:0] idx_id;

   // Scan NREQ candidates starting just after the pointer; first hit wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_id = '0;
      for (int i = 1; i <= NREQ; i++) begin
         // Explicit modulo-NREQ wrap; natural IDW-bit overflow would visit
         // non-existent IDs when NREQ is not a power of two.
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_id = IDW'(idx);
         if (!valid && req[idx_id]) begin
            valid  = 1'b1;
            winner = idx_id;
         end
      end
   end

endmodule

// File: rtl/wordsync_arbiter.sv
// Round-robin arbiter sharing one word-synchronizer source port among NREQ
// requesters. One winner per slot: its word is tagged with its ID, issued
// with a single din_en strobe, and the next slot opens only after the
// synchronizer has dropped and re-raised srdy. A watchdog guards both wait
// states and parks the arbiter in a sticky FAULT until clr_err.
module wordsync_arbiter
   import wordsync_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DWIDTH  = 32,
   parameter int IDW     = clog2(NREQ),
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   wordsync_arbiter_if.master bus
);

   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
   // Pointer starts at the last requester so requester 0 wins first.
   localparam logic [IDW-1:0]    PTR_INIT   = IDW'(NREQ - 1);

   // Control state.
   state_t              state_q;
   state_t              state_d;
   logic [IDW-1:0]      rr_ptr_q;
   logic [WDOG_W-1:0]   wdog_q;
   logic [WDOG_W-1:0]   wdog_d;
   logic [WDOG_W-1:0]   wdog_inc;
   logic                err_q;
   logic                err_d;
   logic                grant;

   // Picker results.
   logic                pick_vld;
   logic [IDW-1:0]      pick_id;
   logic [DWIDTH-1:0]   pick_data;
   logic [NREQ-1:0]     pick_onehot;

   // Registered outputs.
   logic [NREQ-1:0]        gnt_q;
   logic [IDW+DWIDTH-1:0]  din_q;
   logic                   din_en_q;
   logic [IDW-1:0]         cur_id_q;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_vld),
      .winner (pick_id)
   );

   // Select the winner's payload and build its one-hot grant vector.
   always_comb begin
      pick_data   = '0;
      pick_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_id == IDW'(i)) begin
            pick_data      = bus.req_data[i*DWIDTH +: DWIDTH];
            pick_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state, watchdog and fault-flag logic.
   always_comb begin
      state_d  = state_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      grant    = 1'b0;
      wdog_inc = wdog_q + 1'b1;

      case (state_q)
         IDLE: begin
            // No watchdog here: an idle synchronizer may hold srdy low.
            if (pick_vld && bus.sync_srdy) begin
               grant   = 1'b1;
               state_d = WAIT_LO;
               wdog_d  = '0;
            end
         end

         WAIT_LO: begin
            // srdy must fall to show the synchronizer took the word.
            if (!bus.sync_srdy) begin
               state_d = WAIT_HI;
               wdog_d  = '0;
            end else if (wdog_inc == WDOG_LIMIT) begin
               state_d = FAULT;
               wdog_d  = '0;
               err_d   = 1'b1;
            end else begin
               wdog_d  = wdog_inc;
            end
         end

         WAIT_HI: begin
            // srdy back high: the slot is free again. A handshake that
            // completes on the limit cycle wins over the timeout.
            if (bus.sync_srdy) begin
               state_d = IDLE;
               wdog_d  = '0;
            end else if (wdog_inc == WDOG_LIMIT) begin
               state_d = FAULT;
               wdog_d  = '0;
               err_d   = 1'b1;
            end else begin
               wdog_d  = wdog_inc;
            end
         end

         FAULT: begin
            // Only an explicit clear leaves FAULT; clr_err elsewhere is ignored.
            if (bus.clr_err) begin
               state_d = IDLE;
               wdog_d  = '0;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   // Control registers: FSM state, watchdog, fault flag, round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         rr_ptr_q <= PTR_INIT;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
         if (grant) begin
            rr_ptr_q <= pick_id;
         end
      end
   end

   // Output registers: one-cycle grant/strobe, held tagged word and last ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q    <= '0;
         din_en_q <= 1'b0;
         din_q    <= '0;
         cur_id_q <= '0;
      end else begin
         gnt_q    <= grant ? pick_onehot : '0;
         din_en_q <= grant;
         if (grant) begin
            din_q    <= {pick_id, pick_data};
            cur_id_q <= pick_id;
         end
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.sync_din    = din_q;
   assign bus.sync_din_en = din_en_q;
   assign bus.cur_id      = cur_id_q;
   assign bus.timeout_err = err_q;
   assign bus.busy        = (state_q != IDLE);

endmodule
